// File: rtl/rs_alu.sv
// Single-queue reservation station for the ALU: captures operands from the ROB
// broadcast and issues the oldest ready instruction each cycle.
module rs_alu #(
    parameter int RS_ENTRY_NUM  = 4,
    parameter int ROB_ENTRY_NUM = 8,
    parameter int TAG_WIDTH     = 4,
    parameter int COMMON_WIDTH  = 32,
    parameter int OP_WIDTH      = 6
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [OP_WIDTH-1:0]                   in_op,
    input  logic [TAG_WIDTH-1:0]                  in_dest,
    input  logic [TAG_WIDTH-1:0]                  in_qj,
    input  logic [TAG_WIDTH-1:0]                  in_qk,
    input  logic [COMMON_WIDTH-1:0]               in_vj,
    input  logic [COMMON_WIDTH-1:0]               in_vk,
    input  logic [ROB_ENTRY_NUM-1:0]              bc_valid,
    input  logic [ROB_ENTRY_NUM-1:0]              bc_ready,
    input  logic [ROB_ENTRY_NUM*COMMON_WIDTH-1:0] bc_val,
    output logic                                  ex_valid,
    output logic [OP_WIDTH-1:0]                   ex_op,
    output logic [COMMON_WIDTH-1:0]               ex_a,
    output logic [COMMON_WIDTH-1:0]               ex_b,
    output logic [TAG_WIDTH-1:0]                  ex_target
);

    localparam logic [TAG_WIDTH-1:0] TAG_INVALID = '1;
    localparam int RS_IDX_W  = (RS_ENTRY_NUM > 1) ? $clog2(RS_ENTRY_NUM) : 1;
    localparam int ROB_IDX_W = (ROB_ENTRY_NUM > 1) ? $clog2(ROB_ENTRY_NUM) : 1;

    typedef struct packed {
        logic                    busy;
        logic [OP_WIDTH-1:0]     op;
        logic [TAG_WIDTH-1:0]    dest;
        logic [TAG_WIDTH-1:0]    qj;
        logic [COMMON_WIDTH-1:0] vj;
        logic [TAG_WIDTH-1:0]    qk;
        logic [COMMON_WIDTH-1:0] vk;
        logic [7:0]              age;
    } entry_t;

    entry_t ent_q [RS_ENTRY_NUM];
    entry_t ent_d [RS_ENTRY_NUM];

    logic [COMMON_WIDTH-1:0] bc_val_arr [ROB_ENTRY_NUM];

    logic [RS_ENTRY_NUM-1:0] busy_vec;
    logic                    free_found;
    logic [RS_IDX_W-1:0]     free_idx;
    logic                    sel_found;
    logic [RS_IDX_W-1:0]     sel_idx;
    logic [7:0]              sel_age;

    logic                    ex_valid_d;
    logic [OP_WIDTH-1:0]     ex_op_d;
    logic [COMMON_WIDTH-1:0] ex_a_d;
    logic [COMMON_WIDTH-1:0] ex_b_d;
    logic [TAG_WIDTH-1:0]    ex_target_d;

    for (genvar g = 0; g < ROB_ENTRY_NUM; g++) begin : g_bc_unpack
        assign bc_val_arr[g] = bc_val[g*COMMON_WIDTH +: COMMON_WIDTH];
    end

    // Tags outside the ROB range (including TAG_INVALID) never match.
    function automatic logic tag_hit(input logic [TAG_WIDTH-1:0]     tag,
                                     input logic [ROB_ENTRY_NUM-1:0] v,
                                     input logic [ROB_ENTRY_NUM-1:0] r);
        logic [ROB_IDX_W-1:0] idx;
        idx = tag[ROB_IDX_W-1:0];
        return (int'(tag) < ROB_ENTRY_NUM) && v[idx] && r[idx];
    endfunction

    // Free-slot and oldest-ready selection, both from registered state only.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        busy_vec   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_age    = '0;
        for (int i = 0; i < RS_ENTRY_NUM; i++) begin
            busy_vec[i] = ent_q[i].busy;
            if (!ent_q[i].busy && !free_found) begin
                free_found = 1'b1;
                free_idx   = RS_IDX_W'(i);
            end
            if (ent_q[i].busy && ent_q[i].qj == TAG_INVALID && ent_q[i].qk == TAG_INVALID &&
                (!sel_found || ent_q[i].age > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = RS_IDX_W'(i);
                sel_age   = ent_q[i].age;
            end
        end
    end

    assign in_ready = ~&busy_vec;

    always_comb begin
        ent_d       = ent_q;
        ex_valid_d  = 1'b0;
        ex_target_d = TAG_INVALID;
        ex_op_d     = ex_op;
        ex_a_d      = ex_a;
        ex_b_d      = ex_b;

        for (int i = 0; i < RS_ENTRY_NUM; i++) begin
            if (ent_q[i].busy) begin
                if (tag_hit(ent_q[i].qj, bc_valid, bc_ready)) begin
                    ent_d[i].vj = bc_val_arr[ent_q[i].qj[ROB_IDX_W-1:0]];
                    ent_d[i].qj = TAG_INVALID;
                end
                if (tag_hit(ent_q[i].qk, bc_valid, bc_ready)) begin
                    ent_d[i].vk = bc_val_arr[ent_q[i].qk[ROB_IDX_W-1:0]];
                    ent_d[i].qk = TAG_INVALID;
                end
                if (sel_found && sel_idx == RS_IDX_W'(i)) begin
                    ent_d[i].busy = 1'b0;
                end else if (ent_q[i].age != 8'hFF) begin
                    ent_d[i].age = ent_q[i].age + 8'd1;
                end
            end
        end

        if (sel_found) begin
            ex_valid_d  = 1'b1;
            ex_op_d     = ent_q[sel_idx].op;
            ex_a_d      = ent_q[sel_idx].vj;
            ex_b_d      = ent_q[sel_idx].vk;
            ex_target_d = ent_q[sel_idx].dest;
        end

        // The slot written here is free in registered state, so it never collides with issue or snoop.
        if (in_valid && in_ready && !flush) begin
            ent_d[free_idx].busy = 1'b1;
            ent_d[free_idx].op   = in_op;
            ent_d[free_idx].dest = in_dest;
            ent_d[free_idx].age  = 8'd0;
            if (tag_hit(in_qj, bc_valid, bc_ready)) begin
                ent_d[free_idx].qj = TAG_INVALID;
                ent_d[free_idx].vj = bc_val_arr[in_qj[ROB_IDX_W-1:0]];
            end else begin
                ent_d[free_idx].qj = in_qj;
                ent_d[free_idx].vj = in_vj;
            end
            if (tag_hit(in_qk, bc_valid, bc_ready)) begin
                ent_d[free_idx].qk = TAG_INVALID;
                ent_d[free_idx].vk = bc_val_arr[in_qk[ROB_IDX_W-1:0]];
            end else begin
                ent_d[free_idx].qk = in_qk;
                ent_d[free_idx].vk = in_vk;
            end
        end

        if (flush) begin
            for (int i = 0; i < RS_ENTRY_NUM; i++) begin
                ent_d[i].busy = 1'b0;
            end
            ex_valid_d  = 1'b0;
            ex_target_d = TAG_INVALID;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the entry storage is reset in full because reset must zero every field, not just busy.
            for (int i = 0; i < RS_ENTRY_NUM; i++) begin
                ent_q[i] <= '0;
            end
            ex_valid  <= 1'b0;
            ex_target <= TAG_INVALID;
            ex_op     <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            ent_q     <= ent_d;
            ex_valid  <= ex_valid_d;
            ex_target <= ex_target_d;
            ex_op     <= ex_op_d;
            ex_a      <= ex_a_d;
            ex_b      <= ex_b_d;
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: expected issues are queued at dispatch and a
// negedge monitor pops and compares them whenever ex_valid is seen.
module tb_rs_alu;

    localparam int W = 32;
    localparam logic [3:0] TI = 4'hF;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_op;
    logic [3:0]    in_dest;
    logic [3:0]    in_qj;
    logic [3:0]    in_qk;
    logic [W-1:0]  in_vj;
    logic [W-1:0]  in_vk;
    logic [7:0]    bc_valid;
    logic [7:0]    bc_ready;
    logic [8*W-1:0] bc_val;
    logic          ex_valid;
    logic [5:0]    ex_op;
    logic [W-1:0]  ex_a;
    logic [W-1:0]  ex_b;
    logic [3:0]    ex_target;

    typedef struct {
        logic [5:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   target;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    rs_alu dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_dest   (in_dest),
        .in_qj     (in_qj),
        .in_qk     (in_qk),
        .in_vj     (in_vj),
        .in_vk     (in_vk),
        .bc_valid  (bc_valid),
        .bc_ready  (bc_ready),
        .bc_val    (bc_val),
        .ex_valid  (ex_valid),
        .ex_op     (ex_op),
        .ex_a      (ex_a),
        .ex_b      (ex_b),
        .ex_target (ex_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every issue must match the head of the expected queue.
    always @(negedge clk) begin
        if (ex_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_issue_queue_size", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_op", 64'(ex_op), 64'(mon_e.op));
                check("sb_a", 64'(ex_a), 64'(mon_e.a));
                check("sb_b", 64'(ex_b), 64'(mon_e.b));
                check("sb_target", 64'(ex_target), 64'(mon_e.target));
            end
        end else if (!rst) begin
            check("idle_target", 64'(ex_target), 64'(TI));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [3:0] target);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.target = target;
        exp_q.push_back(e);
    endtask

    task automatic set_bc(input int tag, input logic v, input logic r, input logic [W-1:0] val);
        bc_valid[tag] = v;
        bc_ready[tag] = r;
        bc_val[tag*W +: W] = val;
    endtask

    task automatic drive_in(input logic [5:0] op, input logic [3:0] dest, input logic [3:0] qj,
                            input logic [3:0] qk, input logic [W-1:0] vj, input logic [W-1:0] vk);
        in_op = op; in_dest = dest; in_qj = qj; in_qk = qk; in_vj = vj; in_vk = vk;
        in_valid = 1'b1;
    endtask

    // Holds in_valid until an edge sees in_ready; returns just after the accepting edge.
    task automatic dispatch(input logic [5:0] op, input logic [3:0] dest, input logic [3:0] qj,
                            input logic [3:0] qk, input logic [W-1:0] vj, input logic [W-1:0] vk);
        logic acc;
        acc = 1'b0;
        drive_in(op, dest, qj, qk, vj, vk);
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("dispatch_accepted", 64'(acc), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_op = '0; in_dest = '0; in_qj = TI; in_qk = TI; in_vj = '0; in_vk = '0;
        bc_valid = '0; bc_ready = '0; bc_val = '0;

        // Reset
        step(); step();
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_target", 64'(ex_target), 64'(TI));
        check("rst_ex_op", 64'(ex_op), 64'd0);
        check("rst_ex_a", 64'(ex_a), 64'd0);
        check("rst_ex_b", 64'(ex_b), 64'd0);

        // Ready at dispatch: issue one edge after acceptance, then idle with held operands
        expect_issue(6'd1, 32'd3, 32'd4, 4'd2);
        dispatch(6'd1, 4'd2, TI, TI, 32'd3, 32'd4);
        check("ready_no_passthrough", 64'(ex_valid), 64'd0);
        step();
        check("ready_issue_valid", 64'(ex_valid), 64'd1);
        check("ready_issue_target", 64'(ex_target), 64'd2);
        step();
        check("ready_idle_valid", 64'(ex_valid), 64'd0);
        check("ready_idle_target", 64'(ex_target), 64'(TI));
        check("ready_idle_a_held", 64'(ex_a), 64'd3);
        check("ready_idle_b_held", 64'(ex_b), 64'd4);

        // Snoop: operand from tag 5 arrives after three waiting cycles
        set_bc(5, 1'b1, 1'b0, 32'hDEAD);
        expect_issue(6'd2, 32'h10, 32'd7, 4'd3);
        dispatch(6'd2, 4'd3, 4'd5, TI, 32'hBAD0, 32'd7);
        for (int n = 0; n < 3; n++) begin
            step();
            check("snoop_wait_no_issue", 64'(ex_valid), 64'd0);
        end
        set_bc(5, 1'b1, 1'b1, 32'h10);
        step();
        check("snoop_capture_edge_no_issue", 64'(ex_valid), 64'd0);
        set_bc(5, 1'b0, 1'b0, 32'h0);
        step();
        check("snoop_issue_valid", 64'(ex_valid), 64'd1);
        check("snoop_issue_a", 64'(ex_a), 64'h10);
        step();

        // Dispatch-time bypass from a ROB entry that is already ready
        set_bc(6, 1'b1, 1'b1, 32'h55);
        expect_issue(6'd3, 32'h55, 32'd9, 4'd4);
        dispatch(6'd3, 4'd4, 4'd6, TI, 32'h0, 32'd9);
        set_bc(6, 1'b0, 1'b0, 32'h0);
        step();
        check("bypass_issue_valid", 64'(ex_valid), 64'd1);
        check("bypass_issue_a", 64'(ex_a), 64'h55);
        step();

        // Full, a held fifth dispatch, and issue in allocation order
        set_bc(1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            expect_issue(6'(10 + k), 32'h77, 32'(32'h20 + k), 4'(4 + k));
            dispatch(6'(10 + k), 4'(4 + k), 4'd1, TI, 32'h0, 32'(32'h20 + k));
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        expect_issue(6'd14, 32'hA, 32'hB, 4'd2);
        drive_in(6'd14, 4'd2, TI, TI, 32'hA, 32'hB);
        step();
        check("full_held_in_ready", 64'(in_ready), 64'd0);
        step();
        set_bc(1, 1'b1, 1'b1, 32'h77);
        step();
        check("full_capture_no_issue", 64'(ex_valid), 64'd0);
        check("full_capture_in_ready", 64'(in_ready), 64'd0);
        step();
        check("order_0_target", 64'(ex_target), 64'd4);
        check("order_0_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("order_1_target", 64'(ex_target), 64'd5);
        step();
        check("order_2_target", 64'(ex_target), 64'd6);
        step();
        check("order_3_target", 64'(ex_target), 64'd7);
        step();
        check("order_4_fifth_target", 64'(ex_target), 64'd2);
        set_bc(1, 1'b0, 1'b0, 32'h0);
        step();
        check("order_drained_in_ready", 64'(in_ready), 64'd1);

        // Flush with three waiting entries and a simultaneous ready dispatch
        set_bc(3, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            dispatch(6'd20, 4'(k), 4'd3, TI, 32'h0, 32'h1);
        end
        check("flush_pre_in_ready", 64'(in_ready), 64'd1);
        drive_in(6'd21, 4'd6, TI, TI, 32'h1, 32'h2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_ex_valid", 64'(ex_valid), 64'd0);
        check("flush_ex_target", 64'(ex_target), 64'(TI));
        check("flush_in_ready", 64'(in_ready), 64'd1);
        set_bc(3, 1'b1, 1'b1, 32'h33);
        for (int n = 0; n < 4; n++) begin
            step();
            check("flush_no_later_issue", 64'(ex_valid), 64'd0);
        end
        set_bc(3, 1'b0, 1'b0, 32'h0);
        step();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
